spike_tag_queue: RTL and testbench
==================================

Name: spike_tag_queue

Overview:
- Sits directly upstream of the efferent-weight accumulation stage. Buffers the tags of neurons that fired in the current timestep and presents them head-first on fired_tag / fifo_empty, consuming the downstream req_deq.
- Suppresses duplicate tags within a timestep.
- Sequences the end-of-timestep swap handshake once the queue and the downstream stage have drained.

Parameters:
- tagbits, 6, neuron tag width.
- numneurons, 2**tagbits, neurons tracked by the fired bitmap.
- fifobits, 4, log2 queue depth; depth = 2**fifobits = 16.
- stepbits, 16, width of the timestep counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- asyn_reset  input  1  reset, synchronous, active-high (port name kept for codebase consistency; sampled only on posedge clk).
- spike_valid  input  1  neuron update stage presents a fired tag.
- spike_tag  input  tagbits  tag of the fired neuron.
- spike_ready  output  1  queue accepts spike_tag this cycle.
- step_done  input  1  one-cycle pulse: neuron sweep for this timestep finished.
- req_deq  input  1  downstream pops the head entry.
- busy  input  1  downstream accumulation stage is not idle.
- fired_tag  output  tagbits  head entry (show-ahead, combinational from storage).
- fifo_empty  output  1  queue holds no entries.
- swap  output  1  request downstream to swap the next-current buffer.
- step_ack  output  1  one-cycle pulse: timestep fully retired.
- step_count  output  stepbits  retired timestep count.
- step_err  output  1  sticky: step_done arrived outside IDLE.

Behaviour:
- Reset (sync, asyn_reset=1 at posedge):
  - Pointers, count, fired bitmap, storage, step_count, step_err and FSM all go to 0 / IDLE.
  - Outputs after reset: fifo_empty=1, fired_tag=0, spike_ready=1, swap=0, step_ack=0.
  - A reset mid-operation discards all queued tags.
- Queue structure:
  - Circular buffer with wr_ptr, rd_ptr (fifobits) and count (fifobits+1).
  - full = (count == depth); fifo_empty = (count == 0).
  - fired_tag = mem[rd_ptr] with zero latency.
- Accept and dequeue:
  - accept = spike_valid & spike_ready. The producer holds spike_valid/spike_tag stable until accepted.
  - spike_ready = !full & (FSM in IDLE or DRAIN).
  - An accepted tag with seen[spike_tag]=0 is written at wr_ptr, wr_ptr increments, and seen[spike_tag] is set.
  - An accepted tag with seen=1 is consumed and discarded; no write occurs.
  - Dequeue when req_deq & !fifo_empty: rd_ptr increments. req_deq while empty is ignored.
  - Simultaneous write and dequeue leaves count unchanged.
  - Write with count=0 and req_deq in the same cycle: the write happens and the dequeue is ignored.
  - Full is evaluated on the registered count, so a full queue refuses the write even if a dequeue occurs the same cycle.
  - Pointers wrap modulo depth.
- FSM states and transitions:
  - IDLE: step_done goes to DRAIN.
  - DRAIN: when fifo_empty & !busy & !spike_valid, go to SWAP_REQ.
  - SWAP_REQ: swap=1. When busy=1 is sampled, go to SWAP_WAIT.
  - SWAP_WAIT: swap=0. When busy=0, go to IDLE. On that transition, step_ack=1 for one cycle, step_count increments (wraps at 2**stepbits), and all seen bits clear.
- swap timing:
  - swap is decoded from state and is high for 2 cycles in a nominal swap.
  - The downstream stage samples swap only in its wait state, so it performs exactly one swap.
- Error handling:
  - step_done in DRAIN, SWAP_REQ or SWAP_WAIT is ignored and sets step_err. step_err clears only on reset.
- Producer stall: spike_ready=0 during SWAP_REQ and SWAP_WAIT, so next-step spikes stall until IDLE.

Test Plan:
- Basic queue: reset, then enqueue tags 5, 9, 63 with busy=0 and req_deq pulsed once per entry → fired_tag shows 5, 9, 63 in order; fifo_empty returns to 1 after the third pop.
- Duplicate suppression: enqueue 7, 7, 12, 7 in one step → only 7 and 12 are stored; count peaks at 2; all four handshakes complete with spike_ready=1.
- Full boundary: enqueue 16 distinct tags 0..15 with no req_deq → spike_ready=0 at count=16. Holding tag 16 stalls it; one req_deq pop, then the next cycle tag 16 is accepted. Order 0..16 is preserved, including rd_ptr/wr_ptr wrap.
- Swap sequencing:
  - With 2 tags queued, pulse step_done → FSM stays in DRAIN until both tags are popped and busy=0.
  - swap asserts; busy is driven high 1 cycle later, then low.
  - Result: step_ack pulses once, step_count goes 0→1, and tag 5 is accepted again in the new step.
- Error and stall: pulse step_done while in SWAP_WAIT → step_err=1, no second swap. spike_valid presented during SWAP_REQ → spike_ready=0, and the tag is accepted in the first IDLE cycle.
- Reset mid-operation: 3 tags queued and FSM in DRAIN, assert asyn_reset for 1 cycle → fifo_empty=1, fired_tag=0, swap=0, step_count=0; a previously seen tag is accepted again.

Source files
------------

// File: rtl/spike_tag_queue_if.sv
// Handshake and status bundle between the spike tag queue, the neuron update
// stage (producer) and the efferent-weight accumulation stage (consumer).
interface spike_tag_queue_if #(
    parameter int TAGBITS  = 6,
    parameter int STEPBITS = 16
);
    logic                spike_valid;
    logic [TAGBITS-1:0]  spike_tag;
    logic                spike_ready;
    logic                step_done;
    logic                req_deq;
    logic                busy;
    logic [TAGBITS-1:0]  fired_tag;
    logic                fifo_empty;
    logic                swap;
    logic                step_ack;
    logic [STEPBITS-1:0] step_count;
    logic                step_err;

    modport slave (
        input  spike_valid, spike_tag, step_done, req_deq, busy,
        output spike_ready, fired_tag, fifo_empty, swap, step_ack, step_count, step_err
    );

    modport master (
        output spike_valid, spike_tag, step_done, req_deq, busy,
        input  spike_ready, fired_tag, fifo_empty, swap, step_ack, step_count, step_err
    );
endinterface

// File: rtl/spike_tag_queue.sv
// Per-timestep queue of fired neuron tags with duplicate suppression and the
// end-of-timestep drain / swap handshake towards the accumulation stage.
module spike_tag_queue #(
    parameter int TAGBITS    = 6,
    parameter int NUMNEURONS = 2 ** TAGBITS,
    parameter int FIFOBITS   = 4,
    parameter int STEPBITS   = 16
) (
    input  logic           clk,
    input  logic           asyn_reset,
    spike_tag_queue_if.slave q
);
    localparam int DEPTH = 2 ** FIFOBITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAIN     = 2'd1,
        SWAP_REQ  = 2'd2,
        SWAP_WAIT = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TAGBITS-1:0]     mem_q [DEPTH];
    logic [FIFOBITS-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FIFOBITS-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FIFOBITS:0]      count_q, count_d;
    logic [NUMNEURONS-1:0]  seen_q, seen_d;
    logic [STEPBITS-1:0]    step_count_q, step_count_d;
    logic                   step_err_q, step_err_d;

    logic full, empty, accept_ok, accept, do_wr, do_rd, retire;

    assign full      = (count_q == (FIFOBITS+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign accept_ok = (state_q == IDLE) || (state_q == DRAIN);

    // Full uses the registered count, so a same-cycle pop never frees a slot early.
    assign accept = q.spike_valid && q.spike_ready;
    assign do_wr  = accept && !seen_q[q.spike_tag];
    assign do_rd  = q.req_deq && !empty;
    assign retire = (state_q == SWAP_WAIT) && !q.busy;

    assign q.spike_ready = !full && accept_ok;
    assign q.fifo_empty  = empty;
    assign q.fired_tag   = mem_q[rd_ptr_q];
    assign q.swap        = (state_q == SWAP_REQ);
    assign q.step_ack    = retire;
    assign q.step_count  = step_count_q;
    assign q.step_err    = step_err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        seen_d   = seen_q;
        if (do_wr) begin
            wr_ptr_d             = wr_ptr_q + 1'b1;
            seen_d[q.spike_tag]  = 1'b1;
        end
        if (do_rd)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // No accepts happen in SWAP_WAIT, so clearing cannot race a set.
        if (retire)
            seen_d = '0;
    end

    always_comb begin
        state_d      = state_q;
        step_count_d = step_count_q;
        step_err_d   = step_err_q;
        if (q.step_done && state_q != IDLE)
            step_err_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (q.step_done)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (empty && !q.busy && !q.spike_valid)
                    state_d = SWAP_REQ;
            end
            SWAP_REQ: begin
                if (q.busy)
                    state_d = SWAP_WAIT;
            end
            SWAP_WAIT: begin
                if (!q.busy) begin
                    state_d      = IDLE;
                    step_count_d = step_count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            seen_q       <= '0;
            step_count_q <= '0;
            step_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            seen_q       <= seen_d;
            step_count_q <= step_count_d;
            step_err_q   <= step_err_d;
            if (do_wr)
                mem_q[wr_ptr_q] <= q.spike_tag;
        end
    end
endmodule

// File: tb/tb_spike_tag_queue.sv
// Directed bench: stored tags go into a scoreboard queue, a negedge monitor
// checks fired_tag on every real pop; control/status outputs checked inline.
module tb_spike_tag_queue;
    logic clk = 1'b0;
    logic asyn_reset;
    int   total = 0;
    int   bad   = 0;
    logic [5:0] exp_q [$];

    always #5 clk = ~clk;

    spike_tag_queue_if #(.TAGBITS(6), .STEPBITS(16)) bus ();

    spike_tag_queue #(.TAGBITS(6), .FIFOBITS(4), .STEPBITS(16)) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .q          (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted pop must show the next expected tag.
    always @(negedge clk) begin
        if (!asyn_reset && bus.req_deq && !bus.fifo_empty) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0d expected none", bus.fired_tag);
            end else begin
                chk("pop_tag", {26'd0, bus.fired_tag}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        asyn_reset       = 1'b1;
        bus.spike_valid  = 1'b0;
        bus.spike_tag    = '0;
        bus.step_done    = 1'b0;
        bus.req_deq      = 1'b0;
        bus.busy         = 1'b0;
        tick();
        asyn_reset = 1'b0;
        exp_q.delete();
    endtask

    // Offer one tag; 'stored' says whether it should land in the queue.
    task automatic send(input logic [5:0] tag, input bit stored, output int waited);
        bus.spike_valid = 1'b1;
        bus.spike_tag   = tag;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.spike_ready) break;
            waited++;
            if (waited > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got ready=0 expected ready=1 tag %0d", tag);
                break;
            end
        end
        if (stored) exp_q.push_back(tag);
        tick();
        bus.spike_valid = 1'b0;
    endtask

    task automatic pop();
        bus.req_deq = 1'b1;
        tick();
        bus.req_deq = 1'b0;
    endtask

    int w;
    logic [5:0] tags_dup [4] = '{6'd7, 6'd7, 6'd12, 6'd7};
    bit         st_dup   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_empty", bus.fifo_empty, 1);
        chk("rst_tag",   bus.fired_tag, 0);
        chk("rst_ready", bus.spike_ready, 1);
        chk("rst_swap",  bus.swap, 0);
        chk("rst_ack",   bus.step_ack, 0);
        chk("rst_count", bus.step_count, 0);
        chk("rst_err",   bus.step_err, 0);
        tick();

        // Basic ordering
        send(6'd5, 1, w);
        send(6'd9, 1, w);
        send(6'd63, 1, w);
        @(negedge clk);
        chk("basic_head", bus.fired_tag, 5);
        tick();
        pop(); pop(); pop();
        @(negedge clk);
        chk("basic_empty", bus.fifo_empty, 1);
        tick();

        // Duplicate suppression
        for (int i = 0; i < 4; i++) begin
            send(tags_dup[i], st_dup[i], w);
            chk("dup_nostall", w, 0);
        end
        @(negedge clk);
        chk("dup_head", bus.fired_tag, 7);
        tick();
        pop();
        @(negedge clk);
        chk("dup_second", bus.fired_tag, 12);
        tick();
        pop();
        @(negedge clk);
        chk("dup_empty", bus.fifo_empty, 1);
        tick();

        // Full boundary with wrap
        do_reset();
        for (int i = 0; i < 16; i++) send(6'(i), 1, w);
        @(negedge clk);
        chk("full_ready", bus.spike_ready, 0);
        tick();
        bus.spike_valid = 1'b1;
        bus.spike_tag   = 6'd16;
        exp_q.push_back(6'd16);
        tick(); tick();
        @(negedge clk);
        chk("full_stall", bus.spike_ready, 0);
        tick();
        pop();
        @(negedge clk);
        chk("full_ready_after_pop", bus.spike_ready, 1);
        tick();
        bus.spike_valid = 1'b0;
        @(negedge clk);
        chk("full_head", bus.fired_tag, 1);
        chk("full_ready_refull", bus.spike_ready, 0);
        tick();
        for (int i = 0; i < 16; i++) pop();
        @(negedge clk);
        chk("full_drained", bus.fifo_empty, 1);
        tick();

        // Swap sequencing, stall and error
        do_reset();
        send(6'd5, 1, w);
        send(6'd9, 1, w);
        bus.step_done = 1'b1;
        tick();
        bus.step_done = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("drain_hold_swap", bus.swap, 0);
        chk("drain_ready", bus.spike_ready, 1);
        tick();
        pop();
        tick();
        @(negedge clk);
        chk("drain_hold_swap2", bus.swap, 0);
        tick();
        pop();
        @(negedge clk);
        chk("drain_last_swap", bus.swap, 0);
        tick();
        bus.spike_valid = 1'b1;
        bus.spike_tag   = 6'd5;
        @(negedge clk);
        chk("swapreq_swap", bus.swap, 1);
        chk("swapreq_ready", bus.spike_ready, 0);
        tick();
        bus.busy = 1'b1;
        @(negedge clk);
        chk("swapreq_swap2", bus.swap, 1);
        tick();
        bus.step_done = 1'b1;
        @(negedge clk);
        chk("swapwait_swap", bus.swap, 0);
        chk("swapwait_ready", bus.spike_ready, 0);
        tick();
        bus.step_done = 1'b0;
        bus.busy      = 1'b0;
        exp_q.push_back(6'd5);
        @(negedge clk);
        chk("step_err_set", bus.step_err, 1);
        chk("step_ack_pulse", bus.step_ack, 1);
        chk("count_before", bus.step_count, 0);
        tick();
        @(negedge clk);
        chk("step_ack_done", bus.step_ack, 0);
        chk("count_after", bus.step_count, 1);
        chk("idle_ready", bus.spike_ready, 1);
        tick();
        bus.spike_valid = 1'b0;
        @(negedge clk);
        chk("new_step_tag", bus.fired_tag, 5);
        chk("new_step_nonempty", bus.fifo_empty, 0);
        tick();
        tick(); tick();
        @(negedge clk);
        chk("no_second_swap", bus.swap, 0);
        chk("err_sticky", bus.step_err, 1);
        tick();
        pop();

        // Reset mid-operation
        send(6'd20, 1, w);
        send(6'd21, 1, w);
        send(6'd22, 1, w);
        bus.step_done = 1'b1;
        tick();
        bus.step_done = 1'b0;
        tick();
        do_reset();
        @(negedge clk);
        chk("mid_empty", bus.fifo_empty, 1);
        chk("mid_tag", bus.fired_tag, 0);
        chk("mid_swap", bus.swap, 0);
        chk("mid_count", bus.step_count, 0);
        chk("mid_err", bus.step_err, 0);
        chk("mid_ready", bus.spike_ready, 1);
        tick();
        send(6'd20, 1, w);
        @(negedge clk);
        chk("mid_reaccept", bus.fifo_empty, 0);
        chk("mid_reaccept_tag", bus.fired_tag, 20);
        tick();
        pop();
        tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
